// File: rtl/bpuupd_arbiter_pkg.sv
// Shared types and sizing for the branch-predictor update arbiter.
// Holds the queued update entry, the FIFO geometry and the FSM state encoding.
package bpuupd_arbiter_pkg;

  localparam int XLEN              = 32;
  localparam int BPUUPD_FIFO_DEPTH = 4;
  localparam int BPUUPD_PTR_W      = 2;
  localparam int BPUUPD_CNT_W      = 3;

  typedef struct packed {
    logic            wrreq;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] predictedpc;
    logic [2:0]      branchtype;
    logic            predictbit;
  } bpuupd_entry_t;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } bpuupd_state_e;

endpackage

// File: rtl/bpuupd_interface.sv
// Update port toward the branch predictor; the arbiter drives it as master.
// valid is a one-cycle pulse per update; there is no ready, the arbiter watches bpu_stall_i instead.
interface bpuupd_interface;
  import bpuupd_arbiter_pkg::*;

  logic            valid;
  logic            wr_req;
  logic [XLEN-1:0] wr_pc;
  logic [XLEN-1:0] wr_predictedpc;
  logic [2:0]      wr_branchtype;
  logic            wr_predictbit;

  modport master (
    output valid, wr_req, wr_pc, wr_predictedpc, wr_branchtype, wr_predictbit
  );

  modport slave (
    input valid, wr_req, wr_pc, wr_predictedpc, wr_branchtype, wr_predictbit
  );
endinterface

// File: rtl/bpuupd_fifo.sv
// Four-entry update queue: up to two writes and one read per cycle, synchronous flush.
// The second write lands one slot after the first only when the first write is also enabled.
module bpuupd_fifo
  import bpuupd_arbiter_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    arst_i,
  input  logic                    flush_i,
  input  logic [1:0]              wr_en_i,
  input  bpuupd_entry_t           wr_data0_i,
  input  bpuupd_entry_t           wr_data1_i,
  input  logic                    rd_en_i,
  output bpuupd_entry_t           rd_data_o,
  output logic [BPUUPD_CNT_W-1:0] count_o
);

  bpuupd_entry_t           mem_q [BPUUPD_FIFO_DEPTH];
  logic [BPUUPD_PTR_W-1:0] wptr_q;
  logic [BPUUPD_PTR_W-1:0] rptr_q;
  logic [BPUUPD_PTR_W-1:0] wptr_second;
  logic [BPUUPD_CNT_W-1:0] cnt_q;

  assign wptr_second = wptr_q + BPUUPD_PTR_W'(wr_en_i[0]);

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      for (int i = 0; i < BPUUPD_FIFO_DEPTH; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_en_i[0]) mem_q[wptr_q]      <= wr_data0_i;
      if (wr_en_i[1]) mem_q[wptr_second] <= wr_data1_i;
      wptr_q <= wptr_q + BPUUPD_PTR_W'(wr_en_i[0]) + BPUUPD_PTR_W'(wr_en_i[1]);
      rptr_q <= rptr_q + BPUUPD_PTR_W'(rd_en_i);
      cnt_q  <= cnt_q + BPUUPD_CNT_W'(wr_en_i[0]) + BPUUPD_CNT_W'(wr_en_i[1])
                - BPUUPD_CNT_W'(rd_en_i);
    end
  end

  assign rd_data_o = mem_q[rptr_q];
  assign count_o   = cnt_q;

endmodule

// File: rtl/bpuupd_arbiter.sv
// Collects resolved branch updates from two commit slots, queues them and replays
// them one per cycle to the BPU. Handshake: a slot is taken when valid & ready at a clock edge.
module bpuupd_arbiter
  import bpuupd_arbiter_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    arst_i,
  input  logic                    req0_valid_i,
  output logic                    req0_ready_o,
  input  logic                    req0_wrreq_i,
  input  logic [XLEN-1:0]         req0_pc_i,
  input  logic [XLEN-1:0]         req0_predictedpc_i,
  input  logic [2:0]              req0_branchtype_i,
  input  logic                    req0_predictbit_i,
  input  logic                    req1_valid_i,
  output logic                    req1_ready_o,
  input  logic                    req1_wrreq_i,
  input  logic [XLEN-1:0]         req1_pc_i,
  input  logic [XLEN-1:0]         req1_predictedpc_i,
  input  logic [2:0]              req1_branchtype_i,
  input  logic                    req1_predictbit_i,
  input  logic                    bpu_stall_i,
  input  logic                    bpu_enable_i,
  bpuupd_interface.master         bpuupd_mst,
  output logic [BPUUPD_CNT_W-1:0] fifo_cnt_o,
  output bpuupd_state_e           state_o
);

  bpuupd_state_e           state_q, state_d;
  logic [BPUUPD_CNT_W-1:0] count;
  logic                    flush, pop;
  logic                    acc0, acc1, merge;
  bpuupd_entry_t           entry0, entry1, head;
  bpuupd_entry_t           out_q;
  logic                    out_valid_q;

  assign entry0 = '{wrreq: req0_wrreq_i, pc: req0_pc_i, predictedpc: req0_predictedpc_i,
                    branchtype: req0_branchtype_i, predictbit: req0_predictbit_i};
  assign entry1 = '{wrreq: req1_wrreq_i, pc: req1_pc_i, predictedpc: req1_predictedpc_i,
                    branchtype: req1_branchtype_i, predictbit: req1_predictbit_i};

  // Ready depends only on the registered occupancy, so a pop cannot open space the same cycle.
  assign req0_ready_o = (count <= 3'd3);
  assign req1_ready_o = (count <= 3'd2);

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) state_q <= ST_OFF;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OFF:  if (bpu_enable_i) state_d = ST_RUN;
      ST_RUN:  if (!bpu_enable_i) state_d = ST_OFF;
               else if (bpu_stall_i && (count != '0)) state_d = ST_HOLD;
      ST_HOLD: if (!bpu_enable_i) state_d = ST_OFF;
               else if (!bpu_stall_i) state_d = ST_RUN;
      default: state_d = ST_OFF;
    endcase
  end

  // Leaving enable drops the queue at the same edge the FSM enters OFF.
  always_comb begin
    flush = (state_q == ST_OFF) || !bpu_enable_i;
    pop   = (state_q == ST_RUN) && bpu_enable_i && !bpu_stall_i && (count != '0);
  end

  assign acc0  = req0_valid_i && req0_ready_o && !flush;
  assign acc1  = req1_valid_i && req1_ready_o && !flush;
  // Same-PC pair: the younger slot carries the final outcome, the older one is dropped.
  assign merge = acc0 && acc1 && (req0_pc_i == req1_pc_i);

  bpuupd_fifo u_fifo (
    .clk_i      (clk_i),
    .arst_i     (arst_i),
    .flush_i    (flush),
    .wr_en_i    ({acc1, acc0 && !merge}),
    .wr_data0_i (entry0),
    .wr_data1_i (entry1),
    .rd_en_i    (pop),
    .rd_data_o  (head),
    .count_o    (count)
  );

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      out_valid_q <= pop;
      if (pop) out_q <= head;
    end
  end

  assign bpuupd_mst.valid          = out_valid_q;
  assign bpuupd_mst.wr_req         = out_q.wrreq;
  assign bpuupd_mst.wr_pc          = out_q.pc;
  assign bpuupd_mst.wr_predictedpc = out_q.predictedpc;
  assign bpuupd_mst.wr_branchtype  = out_q.branchtype;
  assign bpuupd_mst.wr_predictbit  = out_q.predictbit;
  assign fifo_cnt_o                = count;
  assign state_o                   = state_q;

endmodule

// File: tb/tb_bpuupd_arbiter.sv
// Self-checking bench for bpuupd_arbiter: directed scenarios plus a randomized pair stream,
// with every BPU-side pulse compared against an expected-entry queue.
module tb_bpuupd_arbiter;
  import bpuupd_arbiter_pkg::*;

  localparam int EW = $bits(bpuupd_entry_t);

  logic            clk = 1'b0;
  logic            arst;
  logic            req0_valid, req0_ready, req0_wrreq, req0_predictbit;
  logic [XLEN-1:0] req0_pc, req0_predictedpc;
  logic [2:0]      req0_branchtype;
  logic            req1_valid, req1_ready, req1_wrreq, req1_predictbit;
  logic [XLEN-1:0] req1_pc, req1_predictedpc;
  logic [2:0]      req1_branchtype;
  logic            bpu_stall, bpu_enable;
  logic [2:0]      fifo_cnt;
  bpuupd_state_e   state;

  int n_checks = 0;
  int n_errors = 0;
  int n_pulses = 0;
  logic [EW-1:0] exp_q[$];

  bpuupd_interface bpuupd_if ();

  bpuupd_arbiter dut (
    .clk_i              (clk),
    .arst_i             (arst),
    .req0_valid_i       (req0_valid),
    .req0_ready_o       (req0_ready),
    .req0_wrreq_i       (req0_wrreq),
    .req0_pc_i          (req0_pc),
    .req0_predictedpc_i (req0_predictedpc),
    .req0_branchtype_i  (req0_branchtype),
    .req0_predictbit_i  (req0_predictbit),
    .req1_valid_i       (req1_valid),
    .req1_ready_o       (req1_ready),
    .req1_wrreq_i       (req1_wrreq),
    .req1_pc_i          (req1_pc),
    .req1_predictedpc_i (req1_predictedpc),
    .req1_branchtype_i  (req1_branchtype),
    .req1_predictbit_i  (req1_predictbit),
    .bpu_stall_i        (bpu_stall),
    .bpu_enable_i       (bpu_enable),
    .bpuupd_mst         (bpuupd_if),
    .fifo_cnt_o         (fifo_cnt),
    .state_o            (state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bpuupd_entry_t mk_entry(input logic [31:0] pc, input logic pb, input int slot);
    bpuupd_entry_t e;
    e.wrreq       = 1'b1;
    e.pc          = pc;
    e.predictedpc = pc + 32'h100 + 32'(slot * 8);
    e.branchtype  = pc[4:2];
    e.predictbit  = pb;
    return e;
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input bpuupd_entry_t e);
    req0_valid = 1'b1; req0_wrreq = e.wrreq; req0_pc = e.pc;
    req0_predictedpc = e.predictedpc; req0_branchtype = e.branchtype; req0_predictbit = e.predictbit;
  endtask

  task automatic drive1(input bpuupd_entry_t e);
    req1_valid = 1'b1; req1_wrreq = e.wrreq; req1_pc = e.pc;
    req1_predictedpc = e.predictedpc; req1_branchtype = e.branchtype; req1_predictbit = e.predictbit;
  endtask

  task automatic idle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // scoreboard: every pulse on the BPU port must match the oldest expected entry
  always @(negedge clk) begin
    if (!arst && bpuupd_if.valid) begin
      bpuupd_entry_t act;
      logic [EW-1:0] exp_e;
      act.wrreq       = bpuupd_if.wr_req;
      act.pc          = bpuupd_if.wr_pc;
      act.predictedpc = bpuupd_if.wr_predictedpc;
      act.branchtype  = bpuupd_if.wr_branchtype;
      act.predictbit  = bpuupd_if.wr_predictbit;
      n_pulses++;
      exp_e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      check("out_entry", 128'(act), 128'(exp_e));
    end
  end

  initial begin
    bpuupd_entry_t a, b;
    int p0;
    arst = 1'b1; bpu_stall = 1'b0; bpu_enable = 1'b0;
    req0_valid = 0; req0_wrreq = 0; req0_pc = '0; req0_predictedpc = '0;
    req0_branchtype = '0; req0_predictbit = 0;
    req1_valid = 0; req1_wrreq = 0; req1_pc = '0; req1_predictedpc = '0;
    req1_branchtype = '0; req1_predictbit = 0;

    #12;
    @(negedge clk);
    check("rst_cnt", 128'(fifo_cnt), 128'(0));
    check("rst_valid", 128'(bpuupd_if.valid), 128'(0));
    check("rst_pc", 128'(bpuupd_if.wr_pc), 128'(0));
    check("rst_state", 128'(state), 128'(ST_OFF));
    check("rst_ready0", 128'(req0_ready), 128'(1));
    check("rst_ready1", 128'(req1_ready), 128'(1));

    step(); arst = 1'b0; bpu_enable = 1'b1;
    step();
    check("enable_run", 128'(state), 128'(ST_RUN));

    // single update, two-cycle latency, one-cycle pulse
    a = mk_entry(32'h1000, 1'b1, 0);
    drive0(a); exp_q.push_back(a);
    step(); idle();
    @(negedge clk);
    check("lat_early", 128'(bpuupd_if.valid), 128'(0));
    check("t1_cnt", 128'(fifo_cnt), 128'(1));
    @(negedge clk);
    check("lat_valid", 128'(bpuupd_if.valid), 128'(1));
    check("lat_pc", 128'(bpuupd_if.wr_pc), 128'(32'h1000));
    @(negedge clk);
    check("pulse_end", 128'(bpuupd_if.valid), 128'(0));
    step();

    // two distinct slots, older first
    p0 = n_pulses;
    a = mk_entry(32'h2000, 1'b0, 0); b = mk_entry(32'h2004, 1'b1, 1);
    drive0(a); drive1(b); exp_q.push_back(a); exp_q.push_back(b);
    step(); idle();
    @(negedge clk);
    check("t2_cnt", 128'(fifo_cnt), 128'(2));
    repeat (5) step();
    check("t2_drained", 128'(exp_q.size()), 128'(0));
    check("t2_pulses", 128'(n_pulses - p0), 128'(2));

    // same-pc pair merges into the younger slot
    p0 = n_pulses;
    a = mk_entry(32'h3000, 1'b0, 0); b = mk_entry(32'h3000, 1'b1, 1);
    drive0(a); drive1(b); exp_q.push_back(b);
    step(); idle();
    @(negedge clk);
    check("merge_cnt", 128'(fifo_cnt), 128'(1));
    repeat (5) step();
    check("merge_drained", 128'(exp_q.size()), 128'(0));
    check("merge_pulses", 128'(n_pulses - p0), 128'(1));

    // stall: saturate at 4, ready thresholds, ordered drain after release
    p0 = n_pulses;
    bpu_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a = mk_entry(32'h4000 + 32'(4 * i), 1'(i % 2), 0);
      drive0(a);
      @(negedge clk);
      check("stall_cnt", 128'(fifo_cnt), 128'(i));
      check("stall_ready0", 128'(req0_ready), 128'(i < 4));
      check("stall_ready1", 128'(req1_ready), 128'(i <= 2));
      if (i < 4) exp_q.push_back(a);
      step();
    end
    idle();
    repeat (5) step();
    check("stall_sat", 128'(fifo_cnt), 128'(4));
    check("stall_nopulse", 128'(n_pulses - p0), 128'(0));
    bpu_stall = 1'b0;
    repeat (10) step();
    check("stall_drained", 128'(exp_q.size()), 128'(0));
    check("stall_pulses", 128'(n_pulses - p0), 128'(4));

    // disable with a stalled queue: entries are discarded, nothing is emitted
    p0 = n_pulses;
    bpu_stall = 1'b1;
    drive0(mk_entry(32'h5000, 1'b1, 0)); drive1(mk_entry(32'h5004, 1'b1, 1));
    step();
    idle(); drive0(mk_entry(32'h5008, 1'b0, 0));
    step(); idle();
    @(negedge clk);
    check("dis_cnt3", 128'(fifo_cnt), 128'(3));
    step(); bpu_enable = 1'b0;
    step();
    check("dis_cnt0", 128'(fifo_cnt), 128'(0));
    check("dis_state", 128'(state), 128'(ST_OFF));
    check("dis_ready0", 128'(req0_ready), 128'(1));
    check("dis_ready1", 128'(req1_ready), 128'(1));
    bpu_stall = 1'b0;
    drive0(mk_entry(32'h5100, 1'b1, 0));
    step(); idle();
    check("off_discard", 128'(fifo_cnt), 128'(0));
    repeat (8) step();
    check("dis_nopulse", 128'(n_pulses - p0), 128'(0));
    bpu_enable = 1'b1;
    step();
    check("reenable_run", 128'(state), 128'(ST_RUN));

    // randomized pair stream, occasional same-pc merge
    for (int i = 0; i < 8; i++) begin
      logic [31:0] pc0, pc1;
      logic m;
      pc0 = 32'h7000 + 32'(16 * i);
      m   = ($urandom_range(0, 3) == 0);
      pc1 = m ? pc0 : pc0 + 32'h4;
      a = mk_entry(pc0, 1'($urandom_range(0, 1)), 0);
      b = mk_entry(pc1, 1'($urandom_range(0, 1)), 1);
      drive0(a); drive1(b);
      if (!m) exp_q.push_back(a);
      exp_q.push_back(b);
      step(); idle();
      step();
    end
    repeat (6) step();
    check("rand_drained", 128'(exp_q.size()), 128'(0));

    // asynchronous reset mid-drain
    drive0(mk_entry(32'h6000, 1'b1, 0)); drive1(mk_entry(32'h6004, 1'b0, 1));
    exp_q.push_back(mk_entry(32'h6000, 1'b1, 0)); exp_q.push_back(mk_entry(32'h6004, 1'b0, 1));
    step();
    drive0(mk_entry(32'h6008, 1'b1, 0)); drive1(mk_entry(32'h600c, 1'b0, 1));
    exp_q.push_back(mk_entry(32'h6008, 1'b1, 0)); exp_q.push_back(mk_entry(32'h600c, 1'b0, 1));
    step(); idle();
    @(posedge clk);
    @(negedge clk);
    check("mid_valid", 128'(bpuupd_if.valid), 128'(1));
    check("mid_pc", 128'(bpuupd_if.wr_pc), 128'(32'h6004));
    #2 arst = 1'b1;
    #1;
    check("arst_valid", 128'(bpuupd_if.valid), 128'(0));
    check("arst_cnt", 128'(fifo_cnt), 128'(0));
    check("arst_pc", 128'(bpuupd_if.wr_pc), 128'(0));
    exp_q.delete();
    #1 arst = 1'b0;
    #0.5;
    check("arst_state", 128'(state), 128'(ST_OFF));
    repeat (6) step();
    check("arst_nostale", 128'(exp_q.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
